// File: rtl/bus_pkg.sv
// Shared constants and encodings for the point-to-point system bus link.
// The slave input port uses the same frame widths and state numbering.
package bus_pkg;
   localparam int ADDR_WIDTH = 12;
   localparam int DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } mode_t;
endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out lane: registered LSB-first output, zero fill once drained.
// Load takes priority over shift; sout holds its value when neither is asserted.
module piso_shift #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             sout
);
   logic [WIDTH-1:0] sr;

   // sr holds the bits not yet presented on sout
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr   <= '0;
         sout <= 1'b0;
      end else if (load) begin
         sr   <= din >> 1;
         sout <= din[0];
      end else if (shift) begin
         sr   <= sr >> 1;
         sout <= sr[0];
      end
   end
endmodule

// File: rtl/master_out_port.sv
// Master-side serial transmitter: capture on start, valid/ready handshake, then 12 lane cycles.
// Stalls in REQ until slave_ready; start is ignored unless IDLE.
module master_out_port #(
   parameter int ADDR_WIDTH = bus_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = bus_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  mode,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  slave_ready,
   output logic                  master_valid,
   output logic                  write_en,
   output logic                  read_en,
   output logic                  tx_address,
   output logic                  tx_data,
   output logic                  busy,
   output logic                  tx_done
);
   import bus_pkg::*;

   localparam int CW = $clog2(ADDR_WIDTH);

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [CW-1:0]         cnt;
   logic                  handshake;
   logic                  shift_en;

   assign handshake = (state == REQ) && master_valid && slave_ready;
   assign shift_en  = (state == SHIFT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         addr_q       <= '0;
         data_q       <= '0;
         cnt          <= '0;
         master_valid <= 1'b0;
         write_en     <= 1'b0;
         read_en      <= 1'b0;
         busy         <= 1'b0;
         tx_done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  addr_q       <= addr_in;
                  data_q       <= data_in;
                  state        <= REQ;
                  master_valid <= 1'b1;
                  busy         <= 1'b1;
                  write_en     <= (mode == WRITE);
                  read_en      <= (mode == READ);
               end
            end
            REQ: begin
               if (handshake) begin
                  state        <= SHIFT;
                  cnt          <= '0;
                  master_valid <= 1'b0;
               end
            end
            SHIFT: begin
               // the lanes drain to zero on this same edge via zero fill
               if (cnt == CW'(ADDR_WIDTH - 1)) begin
                  state   <= DONE;
                  tx_done <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               state    <= IDLE;
               tx_done  <= 1'b0;
               write_en <= 1'b0;
               read_en  <= 1'b0;
               busy     <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   piso_shift #(.WIDTH(ADDR_WIDTH)) u_addr_lane (
      .clk   (clk),
      .reset (reset),
      .load  (handshake),
      .shift (shift_en),
      .din   (addr_q),
      .sout  (tx_address)
   );

   piso_shift #(.WIDTH(DATA_WIDTH)) u_data_lane (
      .clk   (clk),
      .reset (reset),
      .load  (handshake),
      .shift (shift_en),
      .din   (data_q),
      .sout  (tx_data)
   );
endmodule
